// File: rtl/audio_write_arbiter.sv
// Fixed-priority arbiter granting one sound source the codec write port; writes every 2nd cycle, stalls on !aud_write_ready.
// Define AUDIO_MIX_EN to instead write a saturated sum of all requesting sources and ack them together.
module audio_write_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 24,
  localparam int OW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ack,
  input  logic                        aud_write_ready,
  output logic                        aud_write,
  output logic [DATA_W-1:0]           aud_write_d,
  output logic [OW-1:0]               owner,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, OWN, WRITE} state_t;
  state_t state;

  logic          any_req;
  logic [OW-1:0] low_idx;

  always_comb begin
    any_req = |src_req;
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req[i]) low_idx = OW'(i);
    end
  end

`ifdef AUDIO_MIX_EN
  localparam int SUM_W = DATA_W + $clog2(NUM_SRC) + 1;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] mix_sat;

  // Sum is in range only when all bits above the data sign bit agree with it.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_req[i])
        sum = sum + {{(SUM_W-DATA_W){src_data[i*DATA_W+DATA_W-1]}}, src_data[i*DATA_W +: DATA_W]};
    end
    if (&sum[SUM_W-1:DATA_W-1] || ~|sum[SUM_W-1:DATA_W-1])
      mix_sat = sum[DATA_W-1:0];
    else if (sum[SUM_W-1])
      mix_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      mix_sat = {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  logic              owner_req;
  logic [DATA_W-1:0] owner_data;
  logic [NUM_SRC-1:0] owner_onehot;

  always_comb begin
    owner_req    = src_req[owner];
    owner_data   = src_data[owner*DATA_W +: DATA_W];
    owner_onehot = NUM_SRC'(1) << owner;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      busy        <= 1'b0;
      aud_write   <= 1'b0;
      aud_write_d <= '0;
      src_ack     <= '0;
    end else begin
      // Strobe, ack and data are single-cycle; zero them unless a write fires now.
      aud_write   <= 1'b0;
      aud_write_d <= '0;
      src_ack     <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= low_idx;
            busy  <= 1'b1;
            state <= OWN;
          end
        end
        OWN: begin
`ifdef AUDIO_MIX_EN
          if (!any_req) begin
            owner <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            owner <= low_idx;
            if (aud_write_ready) begin
              aud_write   <= 1'b1;
              aud_write_d <= mix_sat;
              src_ack     <= src_req;
              state       <= WRITE;
            end
          end
`else
          if (!owner_req) begin
            owner <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (aud_write_ready) begin
            aud_write   <= 1'b1;
            aud_write_d <= owner_data;
            src_ack     <= owner_onehot;
            state       <= WRITE;
          end
`endif
        end
        WRITE: state <= OWN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_write_arbiter.sv
// Scoreboard bench for audio_write_arbiter: a transaction-level model queues expected writes, a negedge monitor checks them.
module tb_audio_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src_req;
  logic [47:0] src_data;
  logic [1:0]  src_ack;
  logic        aud_write_ready;
  logic        aud_write;
  logic [23:0] aud_write_d;
  logic [0:0]  owner;
  logic        busy;

  audio_write_arbiter #(.NUM_SRC(2), .DATA_W(24)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data),
    .src_ack(src_ack), .aud_write_ready(aud_write_ready), .aud_write(aud_write),
    .aud_write_d(aud_write_d), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ack;
    logic [23:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  holder = -1;   // granted source, -1 when nobody holds the port
  bit  cool = 1'b0;   // a write just happened; port rests one cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [1:0] r);
    for (int i = 0; i < 2; i++) if (r[i]) return i;
    return -1;
  endfunction

`ifdef AUDIO_MIX_EN
  function automatic logic [23:0] mix_model(input logic [47:0] d, input logic [1:0] r);
    longint s;
    s = 0;
    for (int i = 0; i < 2; i++) if (r[i]) s += longint'($signed(d[i*24 +: 24]));
    if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
    return s[23:0];
  endfunction
`endif

  // Reference model: decides at each edge whether a write is due and what it carries.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      holder = -1;
      cool   = 1'b0;
      exp_q.delete();
    end else if (holder < 0) begin
      if (src_req != 2'b00) holder = lowest(src_req);
    end else if (cool) begin
      cool = 1'b0;
    end else begin
`ifdef AUDIO_MIX_EN
      if (src_req == 2'b00) holder = -1;
      else begin
        holder = lowest(src_req);
        if (aud_write_ready) begin
          exp_q.push_back({src_req, mix_model(src_data, src_req)});
          cool = 1'b1;
        end
      end
`else
      if (!src_req[holder]) holder = -1;
      else if (aud_write_ready) begin
        exp_q.push_back({2'(1 << holder), src_data[holder*24 +: 24]});
        cool = 1'b1;
      end
`endif
    end
  end

  // Monitor: every negedge compare grant state and any write against the model.
  initial forever begin
    wr_t e;
    bit  exp_w;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(holder >= 0));
    chk("owner", 32'(owner), (holder >= 0) ? 32'(holder) : 32'd0);
    exp_w = (exp_q.size() > 0);
    chk("aud_write", 32'(aud_write), 32'(exp_w));
    if (exp_w) begin
      e = exp_q.pop_front();
      chk("write_data", 32'(aud_write_d), 32'(e.d));
      chk("write_ack", 32'(src_ack), 32'(e.ack));
    end else begin
      chk("idle_data", 32'(aud_write_d), 32'd0);
      chk("idle_ack", 32'(src_ack), 32'd0);
    end
  end

  initial begin
    reset = 1'b1; src_req = '0; src_data = '0; aud_write_ready = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_write", 32'(aud_write), 32'd0);
    @(negedge clk);
    reset = 1'b0; src_req = 2'b01; src_data[23:0] = 24'h000100; aud_write_ready = 1'b1;
    @(negedge clk);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_owner", 32'(owner), 32'd0);
    chk("c1_write", 32'(aud_write), 32'd0);
    @(negedge clk);
    chk("c2_write", 32'(aud_write), 32'd1);
    chk("c2_data", 32'(aud_write_d), 32'h000100);
    chk("c2_ack", 32'(src_ack), 32'd1);
    @(negedge clk);
    chk("c3_write", 32'(aud_write), 32'd0);
    @(negedge clk);
    chk("c4_write", 32'(aud_write), 32'd1);
    src_req = 2'b00; aud_write_ready = 1'b0;
    repeat (2) @(negedge clk);

`ifdef AUDIO_MIX_EN
    src_req = 2'b11; src_data = {24'h300000, 24'h600000}; aud_write_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mix_pos_data", 32'(aud_write_d), 32'h7FFFFF);
    chk("mix_pos_ack", 32'(src_ack), 32'd3);
    src_data = {24'hC00000, 24'hA00000};
    @(negedge clk);
    @(negedge clk);
    chk("mix_neg_data", 32'(aud_write_d), 32'h800000);
    chk("mix_neg_ack", 32'(src_ack), 32'd3);
    src_req = 2'b00; aud_write_ready = 1'b0;
    repeat (2) @(negedge clk);
`else
    src_req = 2'b11;
    @(negedge clk);
    chk("both_owner", 32'(owner), 32'd0);
    chk("both_busy", 32'(busy), 32'd1);
    aud_write_ready = 1'b1;
    repeat (6) @(negedge clk);
    aud_write_ready = 1'b0;
    repeat (2) @(negedge clk);
    src_req = 2'b10;
    @(negedge clk);
    chk("drop_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("handover_owner", 32'(owner), 32'd1);
    chk("handover_busy", 32'(busy), 32'd1);
    src_req = 2'b11; aud_write_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_preempt", 32'(owner), 32'd1);
    end
    aud_write_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_write", 32'(aud_write), 32'd0);
      chk("stall_ack", 32'(src_ack), 32'd0);
    end
    aud_write_ready = 1'b1;
    @(negedge clk);
    chk("resume_write", 32'(aud_write), 32'd1);
    chk("resume_ack", 32'(src_ack), 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("arst_write", 32'(aud_write), 32'd0);
    chk("arst_ack", 32'(src_ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", 32'(aud_write_d), 32'd0);
    @(negedge clk);
    reset = 1'b0; src_req = 2'b00; aud_write_ready = 1'b0;
    @(negedge clk);
`endif

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 5) == 0) src_req[b] = ~src_req[b];
      src_data = {24'($urandom), 24'($urandom)};
      aud_write_ready = ($urandom_range(0, 3) != 0);
    end
    reset = 1'b0; src_req = 2'b00; aud_write_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("end_idle", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
